matmul_mem: RTL and testbench

Single-port local word memory that sits directly downstream of the matmul engine's memory interface. It services the engine's `mem_req` accesses, one per cycle and without backpressure, and returns read data after a fixed latency on `mem_rdata_vld`/`mem_rdata`. A secondary host port loads operands and unloads results, using only cycles the engine leaves idle.

---
 rtl/matmul_mem_pkg.sv | 19 +
 rtl/matmul_mem_if.sv | 36 +++
 rtl/matmul_mem_rdpipe.sv | 82 ++++++++
 rtl/matmul_mem.sv | 84 ++++++++
 tb/tb_matmul_mem.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_mem_pkg.sv
// Shared types and helpers for the matmul local word memory.
package matmul_mem_pkg;

  typedef enum logic {
    PORT_ENG  = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned ADDR_CHK_W = 32;

  // Address is in range when every bit at or above depth_log2 is zero.
  function automatic logic addr_in_range(input logic [ADDR_CHK_W-1:0] addr,
                                         input int unsigned          depth_log2);
    return (addr >> depth_log2) == '0;
  endfunction

endpackage

// File: rtl/matmul_mem_if.sv
// Engine access port plus host load/unload port of the matmul local memory.
interface matmul_mem_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) ();

  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;

  logic          h_req;
  logic          h_write;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rdata_vld;
  logic [DW-1:0] h_rdata;

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata,
    input  h_req, h_write, h_addr, h_wdata,
    output h_gnt, h_rdata_vld, h_rdata
  );

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata,
    output h_req, h_write, h_addr, h_wdata,
    input  h_gnt, h_rdata_vld, h_rdata
  );

endinterface

// File: rtl/matmul_mem_rdpipe.sv
// Read return delay line: LAT-1 tagged stages then a per-port output stage
// that pulses valid and holds data between pulses.
module matmul_mem_rdpipe
  import matmul_mem_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld_i,
  input  port_e         in_tag_i,
  input  logic [DW-1:0] in_data_i,
  output logic          eng_vld_o,
  output logic [DW-1:0] eng_data_o,
  output logic          host_vld_o,
  output logic [DW-1:0] host_data_o
);

  logic          tail_vld;
  port_e         tail_tag;
  logic [DW-1:0] tail_data;

  if (LAT == 1) begin : g_direct
    assign tail_vld  = in_vld_i;
    assign tail_tag  = in_tag_i;
    assign tail_data = in_data_i;
  end else begin : g_line
    localparam int unsigned N = LAT - 1;

    logic          vld_q  [N];
    port_e         tag_q  [N];
    logic [DW-1:0] data_q [N];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < N; i++) begin
          vld_q[i]  <= 1'b0;
          tag_q[i]  <= PORT_ENG;
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0]  <= in_vld_i;
        tag_q[0]  <= in_tag_i;
        data_q[0] <= in_data_i;
        for (int unsigned i = 1; i < N; i++) begin
          vld_q[i]  <= vld_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign tail_vld  = vld_q[N-1];
    assign tail_tag  = tag_q[N-1];
    assign tail_data = data_q[N-1];
  end

  logic          eng_vld_q, host_vld_q;
  logic [DW-1:0] eng_data_q, host_data_q;

  // Steer the returning word to the issuing port only.
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_vld_q   <= 1'b0;
      host_vld_q  <= 1'b0;
      eng_data_q  <= '0;
      host_data_q <= '0;
    end else begin
      eng_vld_q  <= tail_vld && (tail_tag == PORT_ENG);
      host_vld_q <= tail_vld && (tail_tag == PORT_HOST);
      if (tail_vld && (tail_tag == PORT_ENG))  eng_data_q  <= tail_data;
      if (tail_vld && (tail_tag == PORT_HOST)) host_data_q <= tail_data;
    end
  end

  assign eng_vld_o   = eng_vld_q;
  assign eng_data_o  = eng_data_q;
  assign host_vld_o  = host_vld_q;
  assign host_data_o = host_data_q;

endmodule

// File: rtl/matmul_mem.sv
// Single-port local word memory: engine has absolute priority, host uses idle cycles.
module matmul_mem
  import matmul_mem_pkg::*;
#(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned MEM_DW     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic         clk,
  input  logic         rst,
  matmul_mem_if.slave  bus,
  output logic         err_oob_o
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("matmul_mem: RD_LAT must be within 1..4");
  end
  if (DEPTH_LOG2 >= MEM_AW || MEM_AW > ADDR_CHK_W) begin : g_bad_aw
    $error("matmul_mem: DEPTH_LOG2/MEM_AW combination not supported");
  end

  logic                  acc_eng, acc_host, acc_vld, acc_write, acc_inr;
  port_e                 acc_tag;
  logic [MEM_AW-1:0]     acc_addr;
  logic [MEM_DW-1:0]     acc_wdata, rd_data;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [MEM_DW-1:0]     mem_q [DEPTH];
  logic                  err_oob_q;

  // Arbitration and range check for the single accepted access.
  always_comb begin
    acc_eng   = bus.mem_req & ~rst;
    acc_host  = bus.h_req & ~bus.mem_req & ~rst;
    acc_vld   = acc_eng | acc_host;
    acc_write = acc_eng ? bus.mem_write : bus.h_write;
    acc_addr  = acc_eng ? bus.mem_addr  : bus.h_addr;
    acc_wdata = acc_eng ? bus.mem_wdata : bus.h_wdata;
    acc_tag   = acc_eng ? PORT_ENG : PORT_HOST;
    acc_inr   = addr_in_range(ADDR_CHK_W'(acc_addr), DEPTH_LOG2);
    acc_idx   = acc_addr[DEPTH_LOG2-1:0];
    rd_data   = acc_inr ? mem_q[acc_idx] : '0;
  end

  assign bus.h_gnt = acc_host;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_vld && acc_write && acc_inr) mem_q[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)                      err_oob_q <= 1'b0;
    else if (acc_vld && !acc_inr) err_oob_q <= 1'b1;
  end

  assign err_oob_o = err_oob_q;

  logic              eng_vld, host_vld;
  logic [MEM_DW-1:0] eng_data, host_data;

  matmul_mem_rdpipe #(
    .DW  (MEM_DW),
    .LAT (RD_LAT)
  ) u_rdpipe (
    .clk         (clk),
    .rst         (rst),
    .in_vld_i    (acc_vld & ~acc_write),
    .in_tag_i    (acc_tag),
    .in_data_i   (rd_data),
    .eng_vld_o   (eng_vld),
    .eng_data_o  (eng_data),
    .host_vld_o  (host_vld),
    .host_data_o (host_data)
  );

  assign bus.mem_rdata_vld = eng_vld;
  assign bus.mem_rdata     = eng_data;
  assign bus.h_rdata_vld   = host_vld;
  assign bus.h_rdata       = host_data;

endmodule

// File: tb/tb_matmul_mem.sv
// Drives three matmul_mem instances (RD_LAT 1, 2, 4) with identical stimulus
// and checks each against a cycle-level reference model of the memory rules.
module tb_matmul_mem;

  localparam int unsigned LATS [3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_write, h_req, h_write;
  logic [15:0] mem_addr, h_addr;
  logic [31:0] mem_wdata, h_wdata;

  logic        hg  [3];
  logic        mv  [3];
  logic        hv  [3];
  logic        err [3];
  logic [31:0] md  [3];
  logic [31:0] hd  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    matmul_mem_if #(.AW(16), .DW(32)) bus ();
    assign bus.mem_req   = mem_req;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.h_req     = h_req;
    assign bus.h_write   = h_write;
    assign bus.h_addr    = h_addr;
    assign bus.h_wdata   = h_wdata;
    assign hg[g] = bus.h_gnt;
    assign mv[g] = bus.mem_rdata_vld;
    assign md[g] = bus.mem_rdata;
    assign hv[g] = bus.h_rdata_vld;
    assign hd[g] = bus.h_rdata;

    matmul_mem #(
      .MEM_AW(16), .MEM_DW(32), .DEPTH_LOG2(10), .RD_LAT(LATS[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_oob_o (err[g])
    );
  end

  typedef struct {
    int          due;
    int          k;
    logic        port;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    int          k;
    logic        port;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        last_gnt;
  pend_t       pend [$];
  ev_t         evq  [$];
  logic [31:0] mmem [int];
  logic [31:0] exp_md [3];
  logic [31:0] exp_hd [3];
  logic        exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%08h want=%08h", nm, cyc, act, exp);
    end
  endtask

  // One clock: check the grant, update the model, then compare registered outputs.
  task automatic step();
    logic        g, prt, w;
    int          a;
    logic [31:0] d, rdv;
    #1;
    g = h_req && !mem_req && !rst;
    for (int k = 0; k < 3; k++) chk($sformatf("h_gnt[%0d]", k), 32'(hg[k]), 32'(g));
    last_gnt = g;
    if (rst) begin
      pend.delete();
      for (int k = 0; k < 3; k++) begin exp_md[k] = '0; exp_hd[k] = '0; end
      exp_err = 1'b0;
    end else if (mem_req || h_req) begin
      prt = !mem_req;
      w   = mem_req ? mem_write : h_write;
      a   = mem_req ? int'(mem_addr) : int'(h_addr);
      d   = mem_req ? mem_wdata : h_wdata;
      if (a >= 1024) exp_err = 1'b1;
      if (!w) begin
        rdv = (a < 1024 && mmem.exists(a)) ? mmem[a] : 32'h0;
        for (int k = 0; k < 3; k++) pend.push_back('{cyc + int'(LATS[k]), k, prt, rdv});
      end else if (a < 1024) begin
        mmem[a] = d;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      logic ev_m, ev_h;
      ev_m = 1'b0;
      ev_h = 1'b0;
      for (int i = 0; i < pend.size(); ) begin
        if (pend[i].due == cyc && pend[i].k == k) begin
          if (pend[i].port) begin ev_h = 1'b1; exp_hd[k] = pend[i].data; end
          else              begin ev_m = 1'b1; exp_md[k] = pend[i].data; end
          pend.delete(i);
        end else begin
          i++;
        end
      end
      chk($sformatf("mem_vld[%0d]", k), 32'(mv[k]), 32'(ev_m));
      chk($sformatf("mem_rdata[%0d]", k), md[k], exp_md[k]);
      chk($sformatf("h_vld[%0d]", k), 32'(hv[k]), 32'(ev_h));
      chk($sformatf("h_rdata[%0d]", k), hd[k], exp_hd[k]);
      chk($sformatf("err_oob[%0d]", k), 32'(err[k]), 32'(exp_err));
      if (mv[k] === 1'b1) evq.push_back('{k, 1'b0, cyc, md[k]});
      if (hv[k] === 1'b1) evq.push_back('{k, 1'b1, cyc, hd[k]});
    end
  endtask

  task automatic eng(input logic w, input logic [15:0] a, input logic [31:0] d);
    mem_req = 1'b1; mem_write = w; mem_addr = a; mem_wdata = d;
    h_req = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    mem_req = 1'b0; rst = 1'b0;
    h_req = 1'b1; h_write = 1'b1; h_addr = a; h_wdata = d;
    step();
    h_req = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_req = 1'b0; h_req = 1'b0; rst = 1'b0;
    repeat (n) step();
  endtask

  task automatic expect_ev(input string nm, input int k, input logic p, input int c,
                           input logic [31:0] d);
    logic        f;
    logic [31:0] v;
    f = 1'b0;
    v = '0;
    foreach (evq[i]) if (evq[i].k == k && evq[i].port == p && evq[i].cyc == c) begin
      f = 1'b1; v = evq[i].data;
    end
    chk($sformatf("%s_vld[%0d]", nm, k), 32'(f), 32'd1);
    chk($sformatf("%s_data[%0d]", nm, k), v, d);
  endtask

  function automatic int n_ev(input int k, input logic p, input int from);
    int n = 0;
    foreach (evq[i]) if (evq[i].k == k && evq[i].port == p && evq[i].cyc >= from) n++;
    return n;
  endfunction

  function automatic logic [15:0] pick_addr();
    int unsigned r = $urandom_range(0, 19);
    if (r == 0) return 16'h0400 + 16'($urandom_range(0, 15));
    if (r == 1) return 16'hFFFF;
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin
    vec_t vt [6];
    int   t;
    logic h_pend;

    vt[0] = '{16'h0010, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0};
    vt[1] = '{16'h03FF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    vt[2] = '{16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[3] = '{16'h0400, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[4] = '{16'h8000, 32'hCAFE_0000, 32'h0000_0000, 1'b1};
    vt[5] = '{16'hFFFF, 32'h0BAD_F00D, 32'h0000_0000, 1'b1};

    mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    h_req = 1'b0; h_write = 1'b0; h_addr = '0; h_wdata = '0;
    for (int k = 0; k < 3; k++) begin exp_md[k] = '0; exp_hd[k] = '0; end
    exp_err = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    idle(1);

    // Host load then engine reads back-to-back; covers the latency sweep too.
    host_wr(16'd0, 32'h11);
    host_wr(16'd1, 32'h22);
    host_wr(16'd2, 32'h33);
    evq.delete();
    t = cyc;
    eng(1'b0, 16'd0, '0);
    eng(1'b0, 16'd1, '0);
    eng(1'b0, 16'd2, '0);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      expect_ev("load0", k, 1'b0, t + int'(LATS[k]),     32'h11);
      expect_ev("load1", k, 1'b0, t + int'(LATS[k]) + 1, 32'h22);
      expect_ev("load2", k, 1'b0, t + int'(LATS[k]) + 2, 32'h33);
      chk($sformatf("load_cnt[%0d]", k), 32'(n_ev(k, 1'b0, t)), 32'd3);
    end

    // Engine priority over a pending host read.
    evq.delete();
    t = cyc;
    h_req = 1'b1; h_write = 1'b0; h_addr = 16'd1;
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd0; rst = 1'b0;
    repeat (3) step();
    mem_req = 1'b0;
    step();
    h_req = 1'b0;
    idle(6);
    for (int k = 0; k < 3; k++) begin
      expect_ev("prio_host", k, 1'b1, t + 3 + int'(LATS[k]), 32'h22);
      chk($sformatf("prio_hcnt[%0d]", k), 32'(n_ev(k, 1'b1, t)), 32'd1);
      chk($sformatf("prio_mcnt[%0d]", k), 32'(n_ev(k, 1'b0, t)), 32'd3);
    end

    // Write then read the next cycle.
    evq.delete();
    t = cyc;
    eng(1'b1, 16'd5, 32'hDEAD_BEEF);
    eng(1'b0, 16'd5, '0);
    idle(6);
    for (int k = 0; k < 3; k++) expect_ev("turn", k, 1'b0, t + 1 + int'(LATS[k]), 32'hDEAD_BEEF);

    // Range boundary vectors (RD_LAT=2 instance).
    for (int i = 0; i < 6; i++) begin
      evq.delete();
      eng(1'b1, vt[i].addr, vt[i].wdata);
      t = cyc;
      eng(1'b0, vt[i].addr, '0);
      idle(5);
      expect_ev($sformatf("tbl%0d", i), 1, 1'b0, t + 2, vt[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(err[1]), 32'(vt[i].exp_err));
    end
    evq.delete();
    t = cyc;
    eng(1'b0, 16'd0, '0);
    idle(4);
    expect_ev("alias0", 1, 1'b0, t + 2, 32'hFFFF_FFFF);
    chk("oob_sticky", 32'(err[1]), 32'd1);

    // Reset with reads in flight and a host request pending.
    evq.delete();
    t = cyc;
    eng(1'b0, 16'd1, '0);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd2;
    h_req = 1'b1; h_write = 1'b0; h_addr = 16'd1; rst = 1'b1;
    step();
    idle(6);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_late[%0d]", k), 32'(n_ev(k, 1'b0, t + 2) + n_ev(k, 1'b1, t)), 32'd0);
      chk($sformatf("rst_rdata[%0d]", k), md[k], 32'd0);
      chk($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'd0);
    end
    evq.delete();
    t = cyc;
    eng(1'b0, 16'd2, '0);
    idle(5);
    for (int k = 0; k < 3; k++) expect_ev("post_rst", k, 1'b0, t + int'(LATS[k]), 32'h33);

    // Randomized traffic against the model.
    for (int a = 0; a < 32; a++) host_wr(16'(a), $urandom);
    h_pend = 1'b0;
    repeat (3000) begin
      mem_req   = ($urandom_range(0, 99) < 55);
      mem_write = ($urandom_range(0, 2) == 0);
      mem_addr  = pick_addr();
      mem_wdata = $urandom;
      if (!h_pend) begin
        if ($urandom_range(0, 3) == 0) begin
          h_req = 1'b1; h_write = $urandom_range(0, 1) == 1;
          h_addr = pick_addr(); h_wdata = $urandom;
          h_pend = 1'b1;
        end else begin
          h_req = 1'b0;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
      if (last_gnt) begin h_pend = 1'b0; h_req = 1'b0; end
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
